// File: rtl/spi_reg_ctrl_pkg.sv
// Shared definitions for the SPI command sequencer and its register bank.
package spi_reg_pkg;

   localparam int unsigned CMD_RD_BIT  = 7;
   localparam int unsigned CMD_INC_BIT = 6;
   localparam int unsigned ADDR_W      = 6;

   localparam logic [ADDR_W-1:0] RO_BASE = 6'h20;
   localparam logic [ADDR_W-1:0] ID_ADDR = 6'h3F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR_DATA,
      ST_RD_DATA
   } state_t;

   function automatic logic is_rw_addr(input logic [ADDR_W-1:0] addr,
                                       input int unsigned       num_rw);
      return 32'(addr) < num_rw;
   endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI slave shifter and the command sequencer.
interface spi_reg_ctrl_if;

   logic [7:0] rxd_data;
   logic       rxd_flag;
   logic [7:0] txd_data;

   modport master (
      output rxd_data,
      output rxd_flag,
      input  txd_data
   );

   modport slave (
      input  rxd_data,
      input  rxd_flag,
      output txd_data
   );

endinterface

// File: rtl/spi_reg_bank.sv
// Control register array with a single write port and a combinational
// read mux over control, status and ID.
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int unsigned NUM_RW   = 8,
   parameter int unsigned NUM_RO   = 8,
   parameter logic [7:0]  ID_VALUE = 8'hA5
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [7:0]          wr_data,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [7:0]          rd_data,
   input  logic [NUM_RO*8-1:0] status_in,
   output logic [NUM_RW*8-1:0] ctrl_out
);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_out <= '0;
      end else if (wr_en) begin
         for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (wr_addr == ADDR_W'(i)) ctrl_out[8*i +: 8] <= wr_data;
         end
      end
   end

   // ID wins over a status byte if NUM_RO=32 makes the RO window reach 0x3F.
   always_comb begin
      rd_data = '0;
      if (rd_addr == ID_ADDR) begin
         rd_data = ID_VALUE;
      end else begin
         for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_data = ctrl_out[8*i +: 8];
         end
         for (int unsigned i = 0; i < NUM_RO; i++) begin
            if (rd_addr == RO_BASE + ADDR_W'(i)) rd_data = status_in[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command sequencer behind the byte-level SPI slave: decodes command bytes,
// performs register writes/reads and abandons stalled transactions on timeout.
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int unsigned NUM_RW         = 8,
   parameter int unsigned NUM_RO         = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [7:0]  ID_VALUE       = 8'hA5
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   spi_reg_ctrl_if.slave       bus,
   input  logic [NUM_RO*8-1:0] status_in,
   output logic [NUM_RW*8-1:0] ctrl_out,
   output logic                wr_strobe,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic                rd_strobe,
   output logic [ADDR_W-1:0]   rd_addr,
   output logic                busy,
   output logic [7:0]          err_count
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic              inc_q;
   logic [TMR_W-1:0]  timer;
   logic [7:0]        txd_q;

   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] addr_next;
   logic [ADDR_W-1:0] rd_sel;
   logic [7:0]        rd_val;
   logic              bank_wr;
   logic              timeout;

   assign cmd_addr  = bus.rxd_data[ADDR_W-1:0];
   assign addr_next = addr_q + ADDR_W'(1);
   // One read port serves both the first read (command address) and burst prefetch.
   assign rd_sel    = (state == ST_IDLE) ? cmd_addr : addr_next;
   assign bank_wr   = (state == ST_WR_DATA) && bus.rxd_flag && is_rw_addr(addr_q, NUM_RW);
   assign timeout   = (state != ST_IDLE) && (timer == TMR_W'(TIMEOUT_CYCLES - 1));

   assign bus.txd_data = txd_q;
   assign busy         = (state != ST_IDLE);

   spi_reg_bank #(
      .NUM_RW   (NUM_RW),
      .NUM_RO   (NUM_RO),
      .ID_VALUE (ID_VALUE)
   ) u_bank (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .wr_en     (bank_wr),
      .wr_addr   (addr_q),
      .wr_data   (bus.rxd_data),
      .rd_addr   (rd_sel),
      .rd_data   (rd_val),
      .status_in (status_in),
      .ctrl_out  (ctrl_out)
   );

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         inc_q     <= 1'b0;
         timer     <= '0;
         txd_q     <= '0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         rd_strobe <= 1'b0;
         rd_addr   <= '0;
         err_count <= '0;
      end else begin
         wr_strobe <= 1'b0;
         rd_strobe <= 1'b0;

         if (bus.rxd_flag || state == ST_IDLE) timer <= '0;
         else                                  timer <= timer + TMR_W'(1);

         if (bus.rxd_flag) begin
            case (state)
               ST_IDLE: begin
                  addr_q <= cmd_addr;
                  inc_q  <= bus.rxd_data[CMD_INC_BIT];
                  if (bus.rxd_data[CMD_RD_BIT]) begin
                     txd_q <= rd_val;
                     state <= ST_RD_DATA;
                  end else begin
                     state <= ST_WR_DATA;
                  end
               end
               ST_WR_DATA: begin
                  if (bank_wr) begin
                     wr_strobe <= 1'b1;
                     wr_addr   <= addr_q;
                  end else if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
                  if (inc_q) addr_q <= addr_next;
                  else       state  <= ST_IDLE;
               end
               ST_RD_DATA: begin
                  rd_strobe <= 1'b1;
                  rd_addr   <= addr_q;
                  if (inc_q) begin
                     addr_q <= addr_next;
                     txd_q  <= rd_val;
                  end else begin
                     txd_q <= '0;
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end else if (timeout) begin
            // A burst has no length field, so its timeout is the normal end.
            state <= ST_IDLE;
            txd_q <= '0;
            timer <= '0;
            if (!inc_q && err_count != 8'hFF) err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized transaction-level check of spi_reg_ctrl against a register-map model.
module tb_spi_reg_ctrl;

   localparam int unsigned NUM_RW  = 8;
   localparam int unsigned NUM_RO  = 8;
   localparam int unsigned TMO     = 64;
   localparam logic [7:0]  ID      = 8'hA5;
   localparam int          GAP     = 6;

   logic                sys_clk;
   logic                rst_n;
   logic [NUM_RO*8-1:0] status_in;
   logic [NUM_RW*8-1:0] ctrl_out;
   logic                wr_strobe;
   logic [5:0]          wr_addr;
   logic                rd_strobe;
   logic [5:0]          rd_addr;
   logic                busy;
   logic [7:0]          err_count;

   spi_reg_ctrl_if bus ();

   spi_reg_ctrl #(
      .NUM_RW         (NUM_RW),
      .NUM_RO         (NUM_RO),
      .TIMEOUT_CYCLES (TMO),
      .ID_VALUE       (ID)
   ) dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .status_in (status_in),
      .ctrl_out  (ctrl_out),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .rd_strobe (rd_strobe),
      .rd_addr   (rd_addr),
      .busy      (busy),
      .err_count (err_count)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem [NUM_RW];
   logic [7:0] st  [NUM_RO];
   int         err_m;
   logic [7:0] payload [0:3];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_read(input int a);
      if (a == 63)                          return ID;
      if (a < NUM_RW)                       return mem[a];
      if (a >= 32 && a < 32 + int'(NUM_RO)) return st[a - 32];
      return 8'h00;
   endfunction

   function automatic logic [NUM_RW*8-1:0] m_ctrl();
      logic [NUM_RW*8-1:0] v;
      for (int i = 0; i < NUM_RW; i++) v[8*i +: 8] = mem[i];
      return v;
   endfunction

   function automatic int sat_inc(input int e);
      return (e < 255) ? e + 1 : 255;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_RW; i++) mem[i] = 8'h00;
      err_m = 0;
   endtask

   task automatic set_status(input bit rnd);
      for (int i = 0; i < NUM_RO; i++) begin
         st[i] = rnd ? 8'($urandom) : 8'h00;
         status_in[8*i +: 8] = st[i];
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // Returns on the negedge following the edge that consumed the byte.
   task automatic send_byte(input logic [7:0] b);
      @(negedge sys_clk);
      bus.rxd_data = b;
      bus.rxd_flag = 1'b1;
      @(negedge sys_clk);
      bus.rxd_flag = 1'b0;
   endtask

   task automatic end_txn(input bit inc, input int n);
      if (inc || n == 0) begin
         idle(TMO + 2);
         if (!inc) err_m = sat_inc(err_m);
      end
      chk("end_busy", busy, 0);
      chk("end_err", err_count, err_m);
      chk("end_ctrl", ctrl_out, m_ctrl());
      chk("end_txd", bus.txd_data, 0);
   endtask

   task automatic wr_txn(input logic [7:0] cmd, input int n);
      int a;
      int ad;
      a = int'(cmd[5:0]);
      send_byte(cmd);
      chk("wr_cmd_busy", busy, 1);
      idle(GAP);
      for (int k = 0; k < n; k++) begin
         ad = (a + k) % 64;
         send_byte(payload[k]);
         if (ad < NUM_RW) begin
            mem[ad] = payload[k];
            chk("wr_strobe", wr_strobe, 1);
            chk("wr_addr", wr_addr, ad);
         end else begin
            err_m = sat_inc(err_m);
            chk("wr_drop_strobe", wr_strobe, 0);
         end
         chk("wr_err", err_count, err_m);
         idle(1);
         chk("wr_strobe_1cyc", wr_strobe, 0);
         idle(GAP - 1);
      end
      end_txn(cmd[6], n);
   endtask

   task automatic rd_txn(input logic [7:0] cmd, input int n);
      int a;
      a = int'(cmd[5:0]);
      send_byte(cmd);
      chk("rd_first_txd", bus.txd_data, m_read(a));
      chk("rd_cmd_busy", busy, 1);
      idle(GAP);
      for (int k = 0; k < n; k++) begin
         send_byte(8'($urandom));
         chk("rd_strobe", rd_strobe, 1);
         chk("rd_addr", rd_addr, (a + k) % 64);
         chk("rd_next_txd", bus.txd_data, cmd[6] ? m_read((a + k + 1) % 64) : 8'h00);
         idle(1);
         chk("rd_strobe_1cyc", rd_strobe, 0);
         idle(GAP - 1);
      end
      end_txn(cmd[6], n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] cmd;
      int         n;

      rst_n        = 1'b0;
      bus.rxd_data = 8'h00;
      bus.rxd_flag = 1'b0;
      set_status(0);
      model_reset();
      idle(2);
      chk("rst_ctrl", ctrl_out, 0);
      chk("rst_txd", bus.txd_data, 0);
      chk("rst_wr_strobe", wr_strobe, 0);
      chk("rst_rd_strobe", rd_strobe, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_count, 0);
      rst_n = 1'b1;
      idle(2);

      // ID read, single write, burst write running off the map, burst status read
      rd_txn(8'hBF, 1);
      payload[0] = 8'h5A;
      wr_txn(8'h03, 1);
      payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
      wr_txn(8'h46, 3);
      chk("burst_wr_err_is_1", err_count, 1);
      st[0] = 8'h10; st[1] = 8'h20; st[2] = 8'h30;
      for (int i = 0; i < NUM_RO; i++) status_in[8*i +: 8] = st[i];
      rd_txn(8'hE0, 3);

      // Single write with no data: abandoned exactly TMO edges after the command
      send_byte(8'h01);
      idle(TMO - 1);
      chk("tmo_still_busy", busy, 1);
      idle(1);
      err_m = sat_inc(err_m);
      chk("tmo_idle", busy, 0);
      chk("tmo_err", err_count, err_m);
      chk("tmo_ctrl", ctrl_out, m_ctrl());

      // Data byte arriving on the timeout cycle itself is taken as data
      send_byte(8'h02);
      idle(TMO - 2);
      send_byte(8'hC7);
      mem[2] = 8'hC7;
      chk("tmo_race_strobe", wr_strobe, 1);
      chk("tmo_race_addr", wr_addr, 2);
      chk("tmo_race_busy", busy, 0);
      chk("tmo_race_err", err_count, err_m);
      chk("tmo_race_ctrl", ctrl_out, m_ctrl());

      for (int t = 0; t < 40; t++) begin
         set_status(1);
         cmd = 8'($urandom);
         if ($urandom_range(0, 1) == 0) cmd[5:0] = 6'($urandom_range(0, 11));
         else if ($urandom_range(0, 1) == 0) cmd[5:0] = 6'($urandom_range(30, 41));
         n = cmd[6] ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 1));
         for (int k = 0; k < 4; k++) payload[k] = 8'($urandom);
         if (cmd[7]) rd_txn(cmd, n);
         else        wr_txn(cmd, n);
      end

      // Saturation of the error counter
      for (int i = 0; i < 260; i++) begin
         send_byte(8'h10);
         send_byte(8'hEE);
         err_m = sat_inc(err_m);
      end
      chk("err_saturated", err_count, 255);
      chk("err_model", err_count, err_m);

      // Asynchronous reset in the middle of a write
      payload[0] = 8'h99;
      send_byte(8'h04);
      idle(2);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("amid_rst_ctrl", ctrl_out, 0);
      chk("amid_rst_busy", busy, 0);
      chk("amid_rst_err", err_count, 0);
      chk("amid_rst_txd", bus.txd_data, 0);
      chk("amid_rst_wr_addr", wr_addr, 0);
      idle(2);
      rst_n = 1'b1;
      idle(2);
      payload[0] = 8'h77;
      wr_txn(8'h05, 1);
      chk("post_rst_reg5", ctrl_out[8*5 +: 8], 8'h77);
      chk("post_rst_reg4", ctrl_out[8*4 +: 8], 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
